registers: RTL and testbench
============================

REGISTERS -- requirements
Module: registers

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, register width; ADDR_W, default 4, address width; NREGS, default 16 (2**ADDR_W), register count.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all writes occur on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-004 Port RA1 SHALL be an input, ADDR_W bits, read address for port 1.
REQ-005 Port RA2 SHALL be an input, ADDR_W bits, read address for port 2.
REQ-006 Port WA1 SHALL be an input, ADDR_W bits, general write address.
REQ-007 Port WD1 SHALL be an input, DATA_W bits, general write data.
REQ-008 Port R0D SHALL be an input, DATA_W bits, dedicated R0 write data.
REQ-009 Port RD1 SHALL be an output, DATA_W bits, read data for RA1.
REQ-010 Port RD2 SHALL be an output, DATA_W bits, read data for RA2.
REQ-011 Port R0R SHALL be an output, DATA_W bits, continuous content of register 0.
REQ-012 Port RegWrite SHALL be an input, 1 bit, general write enable.
REQ-013 Port R0W SHALL be an input, 1 bit, dedicated R0 write enable.
REQ-014 Positional port order SHALL be: RA1, RA2, WA1, WD1, R0D, RD1, RD2, R0R, RegWrite, R0W, clk, rst.

Function
REQ-015 Storage SHALL be NREGS registers of DATA_W bits, addressed 0..NREGS-1; every register, including register 0, SHALL be writable (no hardwired zero).
REQ-016 RD1 SHALL combinationally equal reg[RA1], and RD2 SHALL combinationally equal reg[RA2], with zero-cycle latency; RA1 and RA2 may be equal.
REQ-017 R0R SHALL combinationally equal reg[0] at all times, independent of RA1 and RA2.
REQ-018 On a rising clk edge with rst high and RegWrite=1, reg[WA1] SHALL load WD1.
REQ-019 On a rising clk edge with rst high and R0W=1, reg[0] SHALL load R0D.
REQ-020 When R0W=1 and RegWrite=1 with WA1=0 on the same edge, R0D SHALL win and WD1 SHALL be discarded.
REQ-021 When R0W=1 and RegWrite=1 with WA1!=0 on the same edge, both writes SHALL take effect.
REQ-022 With both enables low, no register SHALL change.
REQ-023 Read-during-write SHALL have no bypass: RD1, RD2 and R0R show the old value until the clock edge, then the new value immediately after it.
REQ-024 Addresses SHALL be full-range decoded; no out-of-range case exists and no wrap logic is required.

Reset
REQ-025 When rst=0, all registers SHALL clear to 0 asynchronously, without waiting for clk, so RD1, RD2 and R0R read 0.
REQ-026 While rst=0, writes SHALL be ignored regardless of RegWrite and R0W.
REQ-027 Reset asserted mid-operation SHALL override any pending write on that edge.
REQ-028 Deassertion of rst SHALL take effect so that a write enabled on the first rising edge after rst goes high is performed.

Verification
REQ-029 Scenario: rst=0 for one clock period, then RA1=0, RA2=15 -> RD1=0x0000, RD2=0x0000, R0R=0x0000.
REQ-030 Scenario: RegWrite=1, WA1=4, WD1=0x4444, one edge; then WA1=5, WD1=0x5555, one edge; then RegWrite=0, RA1=4, RA2=5 -> RD1=0x4444, RD2=0x5555.
REQ-031 Scenario: R0W=1, R0D=0x0001, RegWrite=0, one edge -> R0R=0x0001 and RD1=0x0001 with RA1=0; with RA1=15, RD1=0x0000 (never written).
REQ-032 Scenario: R0W=1, R0D=0x00AA, RegWrite=1, WA1=0, WD1=0x00BB, one edge -> R0R=0x00AA; repeat with WA1=7 -> reg7=0x00BB and R0R=0x00AA.
REQ-033 Scenario: with reg4=0x4444, drive rst=0 between clock edges -> RD1 (RA1=4) reads 0x0000 before the next edge; a write enabled during reset leaves the target register at 0.
REQ-034 Scenario: RegWrite=1, WA1=3, WD1=0x1234, RA1=3 -> RD1 holds the old value before the edge and reads 0x1234 after it.

Source files
------------

// File: rtl/registers.sv
// Register file with two combinational read ports, one general write port and
// a dedicated register-0 write port. Register 0 is a normal, writable register;
// its contents are also exported continuously on R0R.
module registers #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic [DATA_W-1:0] R0D,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] R0R,
    input  logic              RegWrite,
    input  logic              R0W,
    input  logic              clk,
    input  logic              rst
);

    // Packed storage keeps every register in one variable driven by one process.
    logic [NREGS-1:0][DATA_W-1:0] regs;

    // Storage update: async clear, then general write, then the dedicated R0
    // write. The R0 write is last so it wins a same-edge collision on address 0,
    // while a general write to any other address still lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            if (RegWrite) regs[WA1] <= WD1;
            if (R0W)      regs[0]   <= R0D;
        end
    end

    // Reads are pure muxes off the stored state: no write bypass, new data is
    // visible only after the edge that stores it.
    always_comb begin
        RD1 = regs[RA1];
        RD2 = regs[RA2];
        R0R = regs[0];
    end

endmodule

// File: tb/tb_registers.sv
// Directed self-checking bench for the registers block.
module tb_registers;

    logic [3:0]  RA1, RA2, WA1;
    logic [15:0] WD1, R0D;
    logic [15:0] RD1, RD2, R0R;
    logic        RegWrite, R0W, clk, rst;

    int n_vec = 0;
    int n_err = 0;

    registers #(.DATA_W(16), .ADDR_W(4), .NREGS(16)) dut (
        .RA1(RA1), .RA2(RA2), .WA1(WA1), .WD1(WD1), .R0D(R0D),
        .RD1(RD1), .RD2(RD2), .R0R(R0R),
        .RegWrite(RegWrite), .R0W(R0W), .clk(clk), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; RegWrite = 1'b0; R0W = 1'b0;
        RA1 = 4'd0; RA2 = 4'd0; WA1 = 4'd0; WD1 = 16'h0; R0D = 16'h0;
        tick();
        RA1 = 4'd0; RA2 = 4'd15;
        #1;
        n_vec++; if (RD1 !== 16'h0000) begin n_err++; $display("FAIL reset_rd1 got %h want %h", RD1, 16'h0000); end
        n_vec++; if (RD2 !== 16'h0000) begin n_err++; $display("FAIL reset_rd2 got %h want %h", RD2, 16'h0000); end
        n_vec++; if (R0R !== 16'h0000) begin n_err++; $display("FAIL reset_r0r got %h want %h", R0R, 16'h0000); end
        // Writes during reset are ignored.
        RegWrite = 1'b1; WA1 = 4'd2; WD1 = 16'hFFFF; R0W = 1'b1; R0D = 16'hFFFF;
        tick();
        RegWrite = 1'b0; R0W = 1'b0; RA1 = 4'd2;
        #1;
        n_vec++; if (RD1 !== 16'h0000) begin n_err++; $display("FAIL reset_ignore_wr got %h want %h", RD1, 16'h0000); end
        n_vec++; if (R0R !== 16'h0000) begin n_err++; $display("FAIL reset_ignore_r0w got %h want %h", R0R, 16'h0000); end
        rst = 1'b1;
    endtask

    task automatic test_write();
        RegWrite = 1'b1; WA1 = 4'd4; WD1 = 16'h4444;
        tick();
        WA1 = 4'd5; WD1 = 16'h5555;
        tick();
        RegWrite = 1'b0; RA1 = 4'd4; RA2 = 4'd5;
        #1;
        n_vec++; if (RD1 !== 16'h4444) begin n_err++; $display("FAIL write_rd1 got %h want %h", RD1, 16'h4444); end
        n_vec++; if (RD2 !== 16'h5555) begin n_err++; $display("FAIL write_rd2 got %h want %h", RD2, 16'h5555); end
        RA1 = 4'd5;
        #1;
        n_vec++; if (RD1 !== 16'h5555) begin n_err++; $display("FAIL same_addr_rd1 got %h want %h", RD1, 16'h5555); end
        n_vec++; if (R0R !== 16'h0000) begin n_err++; $display("FAIL write_r0_untouched got %h want %h", R0R, 16'h0000); end
    endtask

    task automatic test_r0();
        R0W = 1'b1; R0D = 16'h0001; RegWrite = 1'b0;
        tick();
        R0W = 1'b0; RA1 = 4'd0;
        #1;
        n_vec++; if (R0R !== 16'h0001) begin n_err++; $display("FAIL r0_r0r got %h want %h", R0R, 16'h0001); end
        n_vec++; if (RD1 !== 16'h0001) begin n_err++; $display("FAIL r0_rd1 got %h want %h", RD1, 16'h0001); end
        RA1 = 4'd15;
        #1;
        n_vec++; if (RD1 !== 16'h0000) begin n_err++; $display("FAIL r15_unwritten got %h want %h", RD1, 16'h0000); end
    endtask

    task automatic test_collision();
        R0W = 1'b1; R0D = 16'h00AA; RegWrite = 1'b1; WA1 = 4'd0; WD1 = 16'h00BB;
        tick();
        #1;
        n_vec++; if (R0R !== 16'h00AA) begin n_err++; $display("FAIL coll_r0_wins got %h want %h", R0R, 16'h00AA); end
        WA1 = 4'd7;
        tick();
        R0W = 1'b0; RegWrite = 1'b0; RA1 = 4'd7;
        #1;
        n_vec++; if (RD1 !== 16'h00BB) begin n_err++; $display("FAIL coll_reg7 got %h want %h", RD1, 16'h00BB); end
        n_vec++; if (R0R !== 16'h00AA) begin n_err++; $display("FAIL coll_r0r got %h want %h", R0R, 16'h00AA); end
    endtask

    task automatic test_hold();
        RegWrite = 1'b0; R0W = 1'b0; WA1 = 4'd4; WD1 = 16'hDEAD; R0D = 16'hBEEF;
        tick();
        RA1 = 4'd4; RA2 = 4'd7;
        #1;
        n_vec++; if (RD1 !== 16'h4444) begin n_err++; $display("FAIL hold_reg4 got %h want %h", RD1, 16'h4444); end
        n_vec++; if (RD2 !== 16'h00BB) begin n_err++; $display("FAIL hold_reg7 got %h want %h", RD2, 16'h00BB); end
        n_vec++; if (R0R !== 16'h00AA) begin n_err++; $display("FAIL hold_r0 got %h want %h", R0R, 16'h00AA); end
    endtask

    task automatic test_rdw();
        RegWrite = 1'b1; WA1 = 4'd3; WD1 = 16'h1234; RA1 = 4'd3;
        #1;
        n_vec++; if (RD1 !== 16'h0000) begin n_err++; $display("FAIL rdw_before got %h want %h", RD1, 16'h0000); end
        tick();
        RegWrite = 1'b0;
        n_vec++; if (RD1 !== 16'h1234) begin n_err++; $display("FAIL rdw_after got %h want %h", RD1, 16'h1234); end
    endtask

    task automatic test_async_reset();
        RA1 = 4'd4;
        #2;
        rst = 1'b0;   // mid-cycle, no edge in sight
        #1;
        n_vec++; if (RD1 !== 16'h0000) begin n_err++; $display("FAIL async_rd1 got %h want %h", RD1, 16'h0000); end
        n_vec++; if (R0R !== 16'h0000) begin n_err++; $display("FAIL async_r0r got %h want %h", R0R, 16'h0000); end
        RegWrite = 1'b1; WA1 = 4'd4; WD1 = 16'h9999;
        tick();
        n_vec++; if (RD1 !== 16'h0000) begin n_err++; $display("FAIL async_wr_ignored got %h want %h", RD1, 16'h0000); end
        rst = 1'b1;   // write still enabled: first edge after release performs it
        tick();
        RegWrite = 1'b0;
        n_vec++; if (RD1 !== 16'h9999) begin n_err++; $display("FAIL release_first_wr got %h want %h", RD1, 16'h9999); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_r0();
        test_collision();
        test_hold();
        test_rdw();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
